// File: rtl/cla_nibble_sequencer.sv
// cla_nibble_sequencer
//   Serial adder/subtractor that reuses one 4-bit carry-lookahead slice,
//   processing one nibble of the operands per clock, LSB nibble first.
//
// Ports
//   i_clk    rising-edge clock
//   i_rst    synchronous active-high reset
//   i_start  request an operation (accepted only in IDLE or DONE)
//   i_sub    0 = a + b + cin, 1 = a - b (sampled with start)
//   i_a      operand A, W = 4*NIBBLES bits (sampled with start)
//   i_b      operand B (sampled with start)
//   i_cin    carry-in for add, ignored for subtract
//   o_busy   high while the operation is in progress
//   o_done   one-cycle pulse, result valid
//   o_sum    W-bit result (held until the next accepted start)
//   o_cout   carry out of bit W-1 (1 = no borrow when subtracting)
//   o_ovf    two's-complement overflow of the W-bit result
module cla_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_sub,
  input  logic [4*NIBBLES-1:0]   i_a,
  input  logic [4*NIBBLES-1:0]   i_b,
  input  logic                   i_cin,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [4*NIBBLES-1:0]   o_sum,
  output logic                   o_cout,
  output logic                   o_ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_c;
  logic            r_cout;
  logic            r_ovf;
  logic            r_busy;
  logic            r_done;
  logic [IW-1:0]   r_idx;

  logic [W-1:0]    w_a_sh;
  logic [W-1:0]    w_b_sh;
  logic [3:0]      w_an;
  logic [3:0]      w_bn;
  logic [3:0]      w_g;
  logic [3:0]      w_p;
  logic [3:0]      w_s;
  logic [4:0]      w_c;

  // Select the current nibble by shifting it down to bit 0.
  assign w_a_sh = r_a >> {r_idx, 2'b00};
  assign w_b_sh = r_b >> {r_idx, 2'b00};
  assign w_an   = w_a_sh[3:0];
  assign w_bn   = w_b_sh[3:0];

  // The single carry-lookahead slice shared by every nibble.
  assign w_g    = w_an & w_bn;
  assign w_p    = w_an | w_bn;
  assign w_c[0] = r_c;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_s    = w_an ^ w_bn ^ w_c[3:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (i_start) begin
            // Subtract is a + ~b + 1, so the invert and the forced carry
            // are applied once here and the slice only ever adds.
            r_a     <= i_a;
            r_b     <= i_sub ? ~i_b : i_b;
            r_c     <= i_sub | i_cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IW'(n)) r_sum[4*n +: 4] <= w_s;
          end
          r_c   <= w_c[4];
          r_idx <= r_idx + IW'(1);
          if (r_idx == IW'(NIBBLES - 1)) begin
            // Overflow: carry into the sign bit differs from carry out of it.
            r_cout  <= w_c[4];
            r_ovf   <= w_c[3] ^ w_c[4];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer (NIBBLES = 4): directed operations with
// literal expected results, plus a per-cycle comparison against an
// arithmetic reference model of the operation timing and result.
module tb_cla_nibble_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_sub = 1'b0;
  logic [W-1:0]  i_a = '0;
  logic [W-1:0]  i_b = '0;
  logic          i_cin = 1'b0;
  logic          o_busy;
  logic          o_done;
  logic [W-1:0]  o_sum;
  logic          o_cout;
  logic          o_ovf;

  int errs = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  cla_nibble_sequencer #(.NIBBLES(N)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_sub   (i_sub),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_cin   (i_cin),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_sum   (o_sum),
    .o_cout  (o_cout),
    .o_ovf   (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining run edges, result computed with plain
  // W+1-bit arithmetic at the moment of acceptance.
  int            m_left = 0;
  logic          m_done = 1'b0;
  logic [W-1:0]  m_sum = '0;
  logic          m_cout = 1'b0;
  logic          m_ovf = 1'b0;
  logic [W-1:0]  p_sum = '0;
  logic          p_cout = 1'b0;
  logic          p_ovf = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] bb;
    logic [W:0]   full;
    if (i_rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_sum  <= p_sum;
        m_cout <= p_cout;
        m_ovf  <= p_ovf;
      end
    end else if (i_start) begin
      bb   = i_sub ? ~i_b : i_b;
      full = {1'b0, i_a} + {1'b0, bb} + {{W{1'b0}}, (i_sub ? 1'b1 : i_cin)};
      p_sum  <= full[W-1:0];
      p_cout <= full[W];
      p_ovf  <= (i_a[W-1] == bb[W-1]) && (full[W-1] != i_a[W-1]);
      m_left <= N;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      m_done <= 1'b0;
    end
  end

  // Per-cycle comparison; the result is only meaningful outside RUN.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_busy", 32'(o_busy), 32'(m_left != 0));
      chk("mdl_done", 32'(o_done), 32'(m_done));
      chk("mdl_excl", 32'(o_busy & o_done), 32'd0);
      if (m_left == 0) begin
        chk("mdl_sum",  32'(o_sum),  32'(m_sum));
        chk("mdl_cout", 32'(o_cout), 32'(m_cout));
        chk("mdl_ovf",  32'(o_ovf),  32'(m_ovf));
      end
    end
  end

  // Present an operation for one cycle, then scramble the inputs so that
  // any late sampling would corrupt the result.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c);
    @(negedge clk);
    i_start = 1'b1; i_a = a; i_b = b; i_sub = s; i_cin = c;
    @(negedge clk);
    i_start = 1'b0; i_a = ~a; i_b = ~b; i_sub = ~s; i_cin = ~c;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = o_busy ? 1 : 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (o_done) begin
        lat = k;
        break;
      end
      if (o_busy) bcnt++;
    end
    if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    int lat, bc;
    start_op(a, b, s, c);
    wait_done(lat, bc);
    chk({name, "_lat"},  32'(lat),    32'd4);
    chk({name, "_sum"},  32'(o_sum),  32'(es));
    chk({name, "_cout"}, 32'(o_cout), 32'(ec));
    chk({name, "_ovf"},  32'(o_ovf),  32'(eo));
  endtask

  initial begin
    int lat, bc, seen;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_sum",  32'(o_sum),  32'd0);
    chk("rst_cout", 32'(o_cout), 32'd0);
    chk("rst_ovf",  32'(o_ovf),  32'd0);
    i_rst  = 1'b0;
    chk_en = 1'b1;

    // Basic add with latency and busy-width checks.
    start_op(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_done(lat, bc);
    chk("add_lat",  32'(lat),    32'd4);
    chk("add_busy", 32'(bc),     32'd4);
    chk("add_sum",  32'(o_sum),  32'h2345);
    chk("add_cout", 32'(o_cout), 32'd0);
    chk("add_ovf",  32'(o_ovf),  32'd0);

    run_op("ripple1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ripple2", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("sovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("subc1",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("subc0",   16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_nb",  16'h9000, 16'h1000, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b0);
    run_op("sub_ov",  16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Result holds through IDLE.
    repeat (3) @(negedge clk);
    chk("hold_sum",  32'(o_sum),  32'hFFFF & 32'h7FFF);
    chk("hold_done", 32'(o_done), 32'd0);
    chk("hold_busy", 32'(o_busy), 32'd0);

    // A second start during RUN is ignored.
    start_op(16'h1000, 16'h0234, 1'b0, 1'b0);
    @(negedge clk);
    i_start = 1'b1; i_a = 16'hAAAA; i_b = 16'h5555; i_sub = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(lat, bc);
    chk("ign_sum",  32'(o_sum),  32'h1234);
    chk("ign_cout", 32'(o_cout), 32'd0);
    @(negedge clk);
    chk("ign_idle", 32'(o_busy), 32'd0);

    // Reset during the second RUN cycle aborts with no done pulse.
    start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_sum",  32'(o_sum),  32'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_done) seen = 1;
    end
    chk("abort_nodone", 32'(seen), 32'd0);
    run_op("post_rst", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

    // Back-to-back: start high across the DONE cycle.
    start_op(16'h0010, 16'h0020, 1'b0, 1'b0);
    wait_done(lat, bc);
    chk("b2b1_sum", 32'(o_sum), 32'h0030);
    i_start = 1'b1; i_a = 16'h0001; i_b = 16'h0002; i_sub = 1'b0; i_cin = 1'b0;
    @(negedge clk);
    i_start = 1'b0; i_a = 16'hFFFF; i_b = 16'hFFFF;
    chk("b2b_done_off", 32'(o_done), 32'd0);
    chk("b2b_busy_on",  32'(o_busy), 32'd1);
    wait_done(lat, bc);
    chk("b2b2_lat", 32'(lat),   32'd4);
    chk("b2b2_sum", 32'(o_sum), 32'h0003);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $fatal(1, "timeout");
  end

endmodule
